// File: rtl/cva6_mem_req_arbiter.sv
// Memory request arbiter: grants one requester at a time onto a tagged memory port
// and routes responses back by transaction ID. Define CVA6_MEMARB_RR_EN for round-robin arbitration.
module cva6_mem_req_arbiter #(
    parameter int unsigned NrPorts   = 3,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned TidWidth  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NrPorts-1:0]           req_valid_i,
    input  logic [NrPorts*AddrWidth-1:0] req_addr_i,
    input  logic [NrPorts-1:0]           req_we_i,
    output logic [NrPorts-1:0]           req_gnt_o,
    output logic                         mem_req_o,
    output logic [AddrWidth-1:0]         mem_addr_o,
    output logic                         mem_we_o,
    output logic [TidWidth-1:0]          mem_tid_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rsp_valid_i,
    input  logic [TidWidth-1:0]          mem_rsp_tid_i,
    output logic [NrPorts-1:0]           rsp_valid_o,
    output logic                         rsp_err_o,
    input  logic                         flush_i,
    output logic                         flush_done_o,
    output logic [TidWidth:0]            outstanding_o
);

    localparam int unsigned NumIds = 2 ** TidWidth;
    localparam int unsigned PortW  = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e                           state_q, state_d;
    logic [PortW-1:0]                 port_q, port_d;
    logic [AddrWidth-1:0]             addr_q, addr_d;
    logic                             we_q, we_d;
    logic [TidWidth-1:0]              tid_q, tid_d;
    logic [NumIds-1:0]                busy_q, busy_d;
    logic [NumIds-1:0][PortW-1:0]     owner_q, owner_d;

    logic                             arb_found;
    logic [PortW-1:0]                 arb_port;
    logic                             free_found;
    logic [TidWidth-1:0]              free_id;

`ifdef CVA6_MEMARB_RR_EN
    logic [PortW-1:0]                 rr_q, rr_d;
    logic [PortW:0]                   arb_sum;

    // Scan ports starting at the pointer, wrapping modulo NrPorts.
    always_comb begin
        arb_found = 1'b0;
        arb_port  = '0;
        arb_sum   = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            arb_sum = {1'b0, rr_q} + (PortW+1)'(i);
            if (arb_sum >= (PortW+1)'(NrPorts)) begin
                arb_sum = arb_sum - (PortW+1)'(NrPorts);
            end
            if (!arb_found && req_valid_i[arb_sum[PortW-1:0]]) begin
                arb_found = 1'b1;
                arb_port  = arb_sum[PortW-1:0];
            end
        end
    end
`else
    always_comb begin
        arb_found = 1'b0;
        arb_port  = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            if (!arb_found && req_valid_i[i]) begin
                arb_found = 1'b1;
                arb_port  = PortW'(i);
            end
        end
    end
`endif

    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_id    = TidWidth'(i);
            end
        end
    end

    always_comb begin
        outstanding_o = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            outstanding_o = outstanding_o + (TidWidth+1)'(busy_q[i]);
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (mem_rsp_valid_i && busy_q[mem_rsp_tid_i]) begin
            rsp_valid_o[owner_q[mem_rsp_tid_i]] = 1'b1;
        end
    end

    // busy_q is already clear during reset; rst_ni keeps the error pulse quiet too.
    assign rsp_err_o  = rst_ni & mem_rsp_valid_i & ~busy_q[mem_rsp_tid_i];
    assign mem_addr_o = addr_q;
    assign mem_we_o   = we_q;
    assign mem_tid_o  = tid_q;

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        addr_d       = addr_q;
        we_d         = we_q;
        tid_d        = tid_q;
        busy_d       = busy_q;
        owner_d      = owner_q;
`ifdef CVA6_MEMARB_RR_EN
        rr_d         = rr_q;
`endif
        req_gnt_o    = '0;
        mem_req_o    = 1'b0;
        flush_done_o = 1'b0;

        // Free first, then mark the newly granted ID; the two never collide.
        if (mem_rsp_valid_i && busy_q[mem_rsp_tid_i]) begin
            busy_d[mem_rsp_tid_i] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (arb_found && free_found) begin
                    port_d  = arb_port;
                    addr_d  = req_addr_i[arb_port*AddrWidth +: AddrWidth];
                    we_d    = req_we_i[arb_port];
                    tid_d   = free_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    req_gnt_o[port_q] = 1'b1;
                    busy_d[tid_q]     = 1'b1;
                    owner_d[tid_q]    = port_q;
`ifdef CVA6_MEMARB_RR_EN
                    rr_d = (port_q == PortW'(NrPorts - 1)) ? '0 : port_q + 1'b1;
`endif
                    state_d = flush_i ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (outstanding_o == '0) begin
                    flush_done_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            port_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            tid_q   <= '0;
            busy_q  <= '0;
            owner_q <= '0;
`ifdef CVA6_MEMARB_RR_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            tid_q   <= tid_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
`ifdef CVA6_MEMARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_cva6_mem_req_arbiter.sv
// Self-checking bench for cva6_mem_req_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cva6_mem_req_arbiter;

    localparam int unsigned NP  = 3;
    localparam int unsigned AW  = 64;
    localparam int unsigned TW  = 2;
    localparam int unsigned NID = 4;
    localparam int unsigned VW  = 1 + AW + 1 + TW + NP + NP + 1 + 1 + TW + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req_valid_i;
    logic [NP*AW-1:0] req_addr_i;
    logic [NP-1:0]    req_we_i;
    logic [NP-1:0]    req_gnt_o;
    logic             mem_req_o;
    logic [AW-1:0]    mem_addr_o;
    logic             mem_we_o;
    logic [TW-1:0]    mem_tid_o;
    logic             mem_gnt_i;
    logic             mem_rsp_valid_i;
    logic [TW-1:0]    mem_rsp_tid_i;
    logic [NP-1:0]    rsp_valid_o;
    logic             rsp_err_o;
    logic             flush_i;
    logic             flush_done_o;
    logic [TW:0]      outstanding_o;

    always #5 clk = ~clk;

    cva6_mem_req_arbiter #(
        .NrPorts   (NP),
        .AddrWidth (AW),
        .TidWidth  (TW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_we_i        (req_we_i),
        .req_gnt_o       (req_gnt_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_tid_o       (mem_tid_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_tid_i   (mem_rsp_tid_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_err_o       (rsp_err_o),
        .flush_i         (flush_i),
        .flush_done_o    (flush_done_o),
        .outstanding_o   (outstanding_o)
    );

    logic [VW-1:0] obs_vec;
    assign obs_vec = {mem_req_o, mem_addr_o, mem_we_o, mem_tid_o, req_gnt_o,
                      rsp_valid_o, rsp_err_o, flush_done_o, outstanding_o};

    // Reference model: a set of busy IDs with owners, one pending request, a drain flag.
    bit            m_busy [NID];
    int            m_owner[NID];
    bit            m_pend;
    int            m_port;
    logic [AW-1:0] m_addr;
    bit            m_we;
    int            m_tid;
    bit            m_drain;
    int            m_rr;

    logic [VW-1:0] exp_vec;
    logic [NP-1:0] e_gnt;
    int            n_cmp  = 0;
    int            n_fail = 0;

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < NID; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NID; i++) begin
            m_busy[i]  = 1'b0;
            m_owner[i] = 0;
        end
        m_pend = 1'b0; m_port = 0; m_addr = '0; m_we = 1'b0; m_tid = 0;
        m_drain = 1'b0; m_rr = 0;
    endtask

    task automatic eval_model();
        logic [NP-1:0] g;
        logic [NP-1:0] rv;
        logic          err;
        logic          done;
        int            cnt;
        #1;
        cnt = busy_count();
        g = '0; rv = '0; err = 1'b0;
        if (m_pend && mem_gnt_i) g[m_port] = 1'b1;
        if (mem_rsp_valid_i) begin
            if (m_busy[mem_rsp_tid_i]) rv[m_owner[mem_rsp_tid_i]] = 1'b1;
            else err = 1'b1;
        end
        done = m_drain && (cnt == 0);
        if (!rst_n) begin
            exp_vec = '0;
            e_gnt   = '0;
        end else begin
            exp_vec = {m_pend, m_addr, m_we, TW'(m_tid), g, rv, err, done, (TW+1)'(cnt)};
            e_gnt   = g;
        end
    endtask

    task automatic model_advance();
        int cnt;
        bit nb[NID];
        int free_id;
        int win;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cnt = busy_count();
        nb  = m_busy;
        if (mem_rsp_valid_i && m_busy[mem_rsp_tid_i]) nb[mem_rsp_tid_i] = 1'b0;
        if (m_pend) begin
            if (mem_gnt_i) begin
                nb[m_tid]      = 1'b1;
                m_owner[m_tid] = m_port;
                m_rr           = (m_port + 1) % NP;
                m_pend         = 1'b0;
                m_drain        = flush_i;
            end
        end else if (m_drain) begin
            if (cnt == 0) m_drain = 1'b0;
        end else if (flush_i) begin
            m_drain = 1'b1;
        end else begin
            free_id = -1;
            for (int i = NID - 1; i >= 0; i--) if (!m_busy[i]) free_id = i;
            win = -1;
            for (int k = 0; k < NP; k++) begin
                int p;
`ifdef CVA6_MEMARB_RR_EN
                p = (m_rr + k) % NP;
`else
                p = k;
`endif
                if (win < 0 && req_valid_i[p]) win = p;
            end
            if (free_id >= 0 && win >= 0) begin
                m_pend = 1'b1;
                m_port = win;
                m_addr = req_addr_i[win*AW +: AW];
                m_we   = req_we_i[win];
                m_tid  = free_id;
            end
        end
        m_busy = nb;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_port(input int k, input bit v, input logic [AW-1:0] a, input bit w);
        req_valid_i[k]         = v;
        req_addr_i[k*AW +: AW] = a;
        req_we_i[k]            = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = '0; req_we_i = '0; req_addr_i = '0;
        mem_gnt_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_tid_i = '0; flush_i = 1'b0;
        model_reset();
        clock_edge();
        clock_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid_i = '1; req_we_i = '1; req_addr_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mem_gnt_i = 1'b1; mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd2; flush_i = 1'b0;
        model_reset();
        eval_model();
        n_cmp++;
        if (obs_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0", obs_vec);
        end
        clock_edge();
        clock_edge();
        eval_model();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", obs_vec, exp_vec);
        end
        req_valid_i = '0; mem_gnt_i = 1'b0; mem_rsp_valid_i = 1'b0;
        rst_n = 1'b1;
        eval_model();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs_vec, exp_vec);
        end
        clock_edge();
    endtask

    task automatic test_first_request();
        do_reset();
        set_port(0, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
        mem_gnt_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) set_port(0, 1'b0, 64'h0000_0000_8000_0000, 1'b0);
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL first_req c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 1) begin
                n_cmp++;
                if ({mem_req_o, mem_addr_o, mem_tid_o, req_gnt_o} !== {1'b1, 64'h0000_0000_8000_0000, 2'd0, 3'b001}) begin
                    n_fail++;
                    $display("FAIL first_req_issue: got req=%b addr=%h tid=%0d gnt=%b expected 1/80000000/0/001",
                             mem_req_o, mem_addr_o, mem_tid_o, req_gnt_o);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (outstanding_o !== 3'd1) begin
                    n_fail++;
                    $display("FAIL first_req_outstanding: got %0d expected 1", outstanding_o);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_id_exhaustion();
        int ports[4] = '{0, 1, 2, 0};
        do_reset();
        mem_gnt_i = 1'b1;
        for (int g = 0; g < 4; g++) begin
            set_port(ports[g], 1'b1, {$urandom, $urandom}, 1'($urandom));
            for (int c = 0; c < 2; c++) begin
                eval_model();
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL exhaust_fill g%0d c%0d: got %h expected %h", g, c, obs_vec, exp_vec);
                end
                clock_edge();
            end
            req_valid_i[ports[g]] = 1'b0;
        end
        set_port(2, 1'b1, 64'h0000_0000_0000_2040, 1'b1);
        for (int c = 0; c < 3; c++) begin
            eval_model();
            n_cmp++;
            if ({mem_req_o, req_gnt_o, outstanding_o} !== {1'b0, 3'b000, 3'd4} || obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL exhaust_stall c%0d: got req=%b gnt=%b out=%0d expected 0/000/4", c, mem_req_o, req_gnt_o, outstanding_o);
            end
            clock_edge();
        end
        mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd1;
        eval_model();
        n_cmp++;
        if ({rsp_valid_o, rsp_err_o} !== {3'b010, 1'b0} || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL exhaust_rsp: got rsp=%b err=%b expected 010/0", rsp_valid_o, rsp_err_o);
        end
        clock_edge();
        mem_rsp_valid_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL exhaust_reuse c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 1) begin
                n_cmp++;
                if ({mem_req_o, mem_tid_o, req_gnt_o} !== {1'b1, 2'd1, 3'b100}) begin
                    n_fail++;
                    $display("FAIL exhaust_reuse_tid: got req=%b tid=%0d gnt=%b expected 1/1/100", mem_req_o, mem_tid_o, req_gnt_o);
                end
            end
            clock_edge();
        end
        req_valid_i[2] = 1'b0;
    endtask

    task automatic test_arbitration_order();
        int            got[$];
        int            exp_ports[4];
        logic [9:0]    got_code;
        logic [9:0]    exp_code;
`ifdef CVA6_MEMARB_RR_EN
        exp_ports = '{0, 1, 2, 0};
`else
        exp_ports = '{0, 0, 0, 0};
`endif
        do_reset();
        for (int k = 0; k < NP; k++) set_port(k, 1'b1, {$urandom, $urandom}, 1'($urandom));
        mem_gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL arb_order c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            for (int k = 0; k < NP; k++) if (req_gnt_o[k] === 1'b1) got.push_back(k);
            clock_edge();
        end
        got_code = {2'(got.size() > 3 ? 0 : got.size()), 8'h00};
        exp_code = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) got_code[2*i +: 2] = 2'(got[i]);
            exp_code[2*i +: 2] = 2'(exp_ports[i]);
        end
        if (got.size() != 4) got_code[9:8] = 2'b11;
        n_cmp++;
        if (got_code !== exp_code) begin
            n_fail++;
            $display("FAIL arb_sequence: got grants %p expected %p", got, exp_ports);
        end
        req_valid_i = '0;
    endtask

    task automatic test_gnt_stall();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        do_reset();
        mem_gnt_i = 1'b0;
        set_port(1, 1'b1, a, 1'b1);
        for (int c = 0; c < 7; c++) begin
            if (c == 6) mem_gnt_i = 1'b1;
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stall c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c >= 1) begin
                n_cmp++;
                if ({mem_req_o, mem_addr_o, mem_we_o, mem_tid_o, req_gnt_o} !==
                    {1'b1, a, 1'b1, 2'd0, (c == 6) ? 3'b010 : 3'b000}) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got addr=%h tid=%0d gnt=%b expected addr=%h tid=0", c, mem_addr_o, mem_tid_o, req_gnt_o, a);
                end
            end
            clock_edge();
        end
        req_valid_i = '0;
    endtask

    task automatic test_flush();
        int            dones;
        logic [NP-1:0] exp_after;
`ifdef CVA6_MEMARB_RR_EN
        exp_after = 3'b100;
`else
        exp_after = 3'b001;
`endif
        do_reset();
        mem_gnt_i = 1'b1;
        for (int g = 0; g < 2; g++) begin
            set_port(g, 1'b1, {$urandom, $urandom}, 1'b0);
            for (int c = 0; c < 2; c++) begin
                eval_model();
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL flush_fill g%0d c%0d: got %h expected %h", g, c, obs_vec, exp_vec);
                end
                clock_edge();
            end
            req_valid_i[g] = 1'b0;
        end
        flush_i = 1'b1;
        for (int k = 0; k < NP; k++) set_port(k, 1'b1, {$urandom, $urandom}, 1'b0);
        dones = 0;
        for (int c = 0; c < 20 && dones == 0; c++) begin
            mem_rsp_valid_i = (c == 3 || c == 6);
            mem_rsp_tid_i   = (c == 3) ? 2'd0 : 2'd1;
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec || req_gnt_o !== 3'b000 || mem_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_drain c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (flush_done_o === 1'b1) dones++;
            clock_edge();
        end
        mem_rsp_valid_i = 1'b0;
        flush_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL flush_after c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (flush_done_o === 1'b1) dones++;
            if (c == 1) begin
                n_cmp++;
                if ({mem_req_o, req_gnt_o} !== {1'b1, exp_after}) begin
                    n_fail++;
                    $display("FAIL flush_resume: got req=%b gnt=%b expected 1/%b", mem_req_o, req_gnt_o, exp_after);
                end
            end
            clock_edge();
        end
        n_cmp++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL flush_done_count: got %0d expected 1", dones);
        end
        req_valid_i = '0;
    endtask

    task automatic test_err_and_async_reset();
        do_reset();
        mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd3;
        eval_model();
        n_cmp++;
        if ({rsp_err_o, rsp_valid_o} !== {1'b1, 3'b000} || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL err_unissued: got err=%b rsp=%b expected 1/000", rsp_err_o, rsp_valid_o);
        end
        clock_edge();
        mem_rsp_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        set_port(0, 1'b1, {$urandom, $urandom}, 1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c == 2) mem_gnt_i = 1'b0;
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL err_setup c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            clock_edge();
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({mem_req_o, outstanding_o} !== {1'b0, 3'd0} || obs_vec !== '0) begin
            n_fail++;
            $display("FAIL async_reset_issue: got req=%b out=%0d expected 0/0", mem_req_o, outstanding_o);
        end
        clock_edge();
        rst_n = 1'b1;
        req_valid_i = '0;
        mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd0;
        eval_model();
        n_cmp++;
        if ({rsp_err_o, rsp_valid_o} !== {1'b1, 3'b000} || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL err_after_reset: got err=%b rsp=%b expected 1/000", rsp_err_o, rsp_valid_o);
        end
        clock_edge();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic test_random();
        logic [NP-1:0] prev_gnt;
        do_reset();
        prev_gnt = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NP; k++) begin
                if (prev_gnt[k] || (!req_valid_i[k] && $urandom_range(2) == 0))
                    set_port(k, 1'($urandom_range(1)), {$urandom, $urandom}, 1'($urandom));
            end
            mem_gnt_i       = 1'($urandom_range(1));
            mem_rsp_valid_i = ($urandom_range(2) == 0);
            mem_rsp_tid_i   = 2'($urandom_range(3));
            if (!flush_i) flush_i = ($urandom_range(39) == 0);
            else          flush_i = ($urandom_range(5) != 0);
            eval_model();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            prev_gnt = e_gnt;
            clock_edge();
        end
        req_valid_i = '0; mem_rsp_valid_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_request();
        test_id_exhaustion();
        test_arbitration_order();
        test_gnt_stall();
        test_flush();
        test_err_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cva6_mem_req_arbiter.md
CVA6_MEM_REQ_ARBITER -- requirements
Module: cva6_mem_req_arbiter

Interface
REQ-001 Parameter NrPorts, default 3: number of requesters (0=icache refill, 1=dcache load miss, 2=write buffer).
REQ-002 Parameter AddrWidth, default 64: memory request address width.
REQ-003 Parameter TidWidth, default 2: transaction ID width; 2**TidWidth IDs may be outstanding.
REQ-004 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 req_valid_i  in  NrPorts  per-port request valid.
REQ-007 req_addr_i  in  NrPorts*AddrWidth  per-port address; port k occupies bits [k*AddrWidth +: AddrWidth].
REQ-008 req_we_i  in  NrPorts  per-port write flag.
REQ-009 req_gnt_o  out  NrPorts  one-cycle grant pulse to the accepted port.
REQ-010 mem_req_o / mem_addr_o / mem_we_o / mem_tid_o  out  1/AddrWidth/1/TidWidth  request to memory.
REQ-011 mem_gnt_i  in  1  memory accepts the request in the cycle it is high with mem_req_o.
REQ-012 mem_rsp_valid_i / mem_rsp_tid_i  in  1/TidWidth  memory response and its ID.
REQ-013 rsp_valid_o  out  NrPorts  response routed to the owning port.
REQ-014 rsp_err_o  out  1  pulse: response for an ID not outstanding.
REQ-015 flush_i  in  1  level request to drain; flush_done_o  out  1  one-cycle pulse when drained.
REQ-016 outstanding_o  out  TidWidth+1  count of busy IDs.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN; transitions evaluated each rising edge.
REQ-018 IDLE: flush_i high -> DRAIN; else any req_valid_i high and a free ID -> latch winner port, address, we, lowest-index free ID -> ISSUE; else stay.
REQ-019 ISSUE: mem_req_o=1 with latched fields held stable until mem_gnt_i; on mem_gnt_i, req_gnt_o[winner]=1 in that same cycle, ID marked busy with owner=winner, next state DRAIN if flush_i high, else IDLE.
REQ-020 DRAIN: no arbitration; when outstanding_o==0, flush_done_o=1 for one cycle and next state IDLE.
REQ-021 Latency: req_valid_i sampled in IDLE at cycle N -> mem_req_o high at N+1; earliest req_gnt_o at N+1.
REQ-022 Requesters hold req_valid_i, address and we until req_gnt_o; arbiter does not re-sample a latched request.
REQ-023 All IDs busy: arbiter stays in IDLE, no mem_req_o, no grant.
REQ-024 Response: mem_rsp_valid_i with busy ID -> rsp_valid_o[owner]=1 same cycle (combinational); ID free from next cycle.
REQ-025 Response for non-busy ID: no rsp_valid_o, rsp_err_o=1 same cycle, state unchanged.
REQ-026 Simultaneous grant and response: both take effect; outstanding_o net change 0; freed ID not reusable until next cycle.
REQ-027 outstanding_o equals popcount of busy vector; never exceeds 2**TidWidth.

Reset
REQ-028 rst_ni low: FSM=IDLE, busy vector and owners cleared, round-robin pointer=0, latched fields=0, all outputs 0, immediately and regardless of clock.
REQ-029 Reset mid-ISSUE or with IDs outstanding discards them; later responses for those IDs give rsp_err_o.

Configuration
REQ-030 Macro CVA6_MEMARB_RR_EN defined: round-robin; after grant to port k, priority order starts at (k+1) mod NrPorts.
REQ-031 Macro undefined: fixed priority, lowest port index wins; no pointer state.

Verification
REQ-032 Reset then req_valid_i=3'b001, addr 0x8000_0000, mem_gnt_i high -> mem_req_o at cycle 1, mem_tid_o=0, req_gnt_o=3'b001 at cycle 1, outstanding_o=1.
REQ-033 Four grants with no responses, fifth request on port 2 -> no mem_req_o, outstanding_o=4; response tid 1 -> rsp_valid_o to owner, next grant uses tid 1.
REQ-034 RR_EN defined, req_valid_i=3'b111 held, mem_gnt_i=1 -> grant order port 0,1,2,0; undefined -> port 0 granted every time.
REQ-035 mem_gnt_i low 5 cycles in ISSUE -> mem_addr_o/mem_tid_o stable, no req_gnt_o until gnt.
REQ-036 Two outstanding, flush_i=1 -> no further grants; after both responses flush_done_o pulses once, FSM IDLE.
REQ-037 mem_rsp_valid_i with tid 3 never issued -> rsp_err_o=1, rsp_valid_o=0; rst_ni low in ISSUE -> mem_req_o=0 without a clock edge.
